// File: rtl/card_slot_scheduler.sv
// card_slot_scheduler
// Shares one card-digit renderer between NUM_SLOTS on-screen card positions.
// Game logic writes slot descriptors into a shadow table; the shadow table is
// copied to the active table in a single COMMIT cycle at frame start so the
// picture never tears. Every pixel clock, the topmost (highest index) visible
// active slot covering (x_cnt, y_cnt) is selected and registered toward the
// renderer.
// Optional feature macro: BLINK_EN -- per-slot blink bit plus a 6-bit frame
// counter; blinking slots are hidden while frame counter bit 5 is set.
module card_slot_scheduler #(
  parameter int NUM_SLOTS = 8,
  parameter int CARD_W    = 30,
  parameter int CARD_H    = 50,
  localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             clear_req,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_slot,
  input  logic [3:0]       wr_value,
  input  logic [1:0]       wr_color,
  input  logic [9:0]       wr_x,
  input  logic [9:0]       wr_y,
  input  logic             wr_vis,
  input  logic             wr_blink,
  input  logic [9:0]       x_cnt,
  input  logic [9:0]       y_cnt,
  output logic             hit,
  output logic [3:0]       sel_value,
  output logic [1:0]       sel_color,
  output logic [9:0]       sel_x_pin,
  output logic [9:0]       sel_y_pin,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             clr_pend_r;
  logic             frm_pend_r;
  logic [IDX_W-1:0] clr_idx_r;
  logic             clr_last_s;
  logic             wr_en_s;

  // Shadow (written by game logic) and active (seen by the lookup) tables
  logic             sh_vis_r [NUM_SLOTS];
  logic [3:0]       sh_val_r [NUM_SLOTS];
  logic [1:0]       sh_col_r [NUM_SLOTS];
  logic [9:0]       sh_x_r   [NUM_SLOTS];
  logic [9:0]       sh_y_r   [NUM_SLOTS];
  logic             ac_vis_r [NUM_SLOTS];
  logic [3:0]       ac_val_r [NUM_SLOTS];
  logic [1:0]       ac_col_r [NUM_SLOTS];
  logic [9:0]       ac_x_r   [NUM_SLOTS];
  logic [9:0]       ac_y_r   [NUM_SLOTS];

`ifdef BLINK_EN
  logic             sh_blink_r [NUM_SLOTS];
  logic             ac_blink_r [NUM_SLOTS];
  logic [5:0]       frame_cnt_r;
`else
  // Blink input has no function in this build
  logic             unused_blink_s;
  assign unused_blink_s = wr_blink;
`endif

  logic [NUM_SLOTS-1:0] elig_s;
  logic [NUM_SLOTS-1:0] cover_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic                 hit_s;
  logic [3:0]           sel_value_s;
  logic [1:0]           sel_color_s;
  logic [9:0]           sel_x_pin_s;
  logic [9:0]           sel_y_pin_s;

  assign clr_last_s = (clr_idx_r == IDX_W'(NUM_SLOTS - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; frame start beats a clear request arriving together
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_start) begin
          state_nxt_s = ST_COMMIT;
        end else if (clear_req || clr_pend_r) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (clr_pend_r) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (!clr_last_s) begin
          state_nxt_s = ST_CLEAR;
        end else if (frm_pend_r || frame_start) begin
          state_nxt_s = ST_COMMIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: busy flag and write acceptance
  always_comb begin
    busy     = 1'b0;
    wr_ready = 1'b0;
    if (state_r == ST_IDLE) begin
      busy     = 1'b0;
      wr_ready = !frame_start && !clr_pend_r;
    end else begin
      busy     = 1'b1;
      wr_ready = 1'b0;
    end
    wr_en_s = wr_valid && wr_ready;
  end

  // Pending clear / pending frame-start latches and the clear sweep index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_pend_r <= 1'b0;
      frm_pend_r <= 1'b0;
      clr_idx_r  <= {IDX_W{1'b0}};
    end else begin
      if (state_nxt_s == ST_CLEAR) begin
        clr_pend_r <= 1'b0;
      end else if (clear_req && (state_r != ST_CLEAR)) begin
        clr_pend_r <= 1'b1;
      end
      if (state_nxt_s == ST_COMMIT) begin
        frm_pend_r <= 1'b0;
      end else if ((state_r == ST_CLEAR) && frame_start) begin
        frm_pend_r <= 1'b1;
      end
      if (state_r == ST_CLEAR) begin
        clr_idx_r <= clr_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
        clr_idx_r <= {IDX_W{1'b0}};
      end
    end
  end

  // Shadow table: descriptor writes in IDLE, one slot zeroed per CLEAR cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sh_vis_r[i] <= 1'b0;
        sh_val_r[i] <= 4'd0;
        sh_col_r[i] <= 2'd0;
        sh_x_r[i]   <= 10'd0;
        sh_y_r[i]   <= 10'd0;
`ifdef BLINK_EN
        sh_blink_r[i] <= 1'b0;
`endif
      end
    end else if (wr_en_s) begin
      sh_vis_r[wr_slot] <= wr_vis;
      sh_val_r[wr_slot] <= (wr_value > 4'd9) ? 4'd0 : wr_value;
      sh_col_r[wr_slot] <= wr_color;
      sh_x_r[wr_slot]   <= wr_x;
      sh_y_r[wr_slot]   <= wr_y;
`ifdef BLINK_EN
      sh_blink_r[wr_slot] <= wr_blink;
`endif
    end else if (state_r == ST_CLEAR) begin
      sh_vis_r[clr_idx_r] <= 1'b0;
      sh_val_r[clr_idx_r] <= 4'd0;
      sh_col_r[clr_idx_r] <= 2'd0;
      sh_x_r[clr_idx_r]   <= 10'd0;
      sh_y_r[clr_idx_r]   <= 10'd0;
`ifdef BLINK_EN
      sh_blink_r[clr_idx_r] <= 1'b0;
`endif
    end
  end

  // Active table: whole shadow table copied in the single COMMIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ac_vis_r[i] <= 1'b0;
        ac_val_r[i] <= 4'd0;
        ac_col_r[i] <= 2'd0;
        ac_x_r[i]   <= 10'd0;
        ac_y_r[i]   <= 10'd0;
`ifdef BLINK_EN
        ac_blink_r[i] <= 1'b0;
`endif
      end
    end else if (state_r == ST_COMMIT) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ac_vis_r[i] <= sh_vis_r[i];
        ac_val_r[i] <= sh_val_r[i];
        ac_col_r[i] <= sh_col_r[i];
        ac_x_r[i]   <= sh_x_r[i];
        ac_y_r[i]   <= sh_y_r[i];
`ifdef BLINK_EN
        ac_blink_r[i] <= sh_blink_r[i];
`endif
      end
    end
  end

`ifdef BLINK_EN
  // Frame counter advances once per COMMIT and drives the blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 6'd0;
    end else if (state_r == ST_COMMIT) begin
      frame_cnt_r <= frame_cnt_r + 6'd1;
    end
  end
`endif

  // Per-slot eligibility and coverage; 11-bit sums keep pin+size from wrapping
  always_comb begin
    elig_s  = {NUM_SLOTS{1'b0}};
    cover_s = {NUM_SLOTS{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
`ifdef BLINK_EN
      elig_s[i] = ac_vis_r[i] && !(ac_blink_r[i] && frame_cnt_r[5]);
`else
      elig_s[i] = ac_vis_r[i];
`endif
      cover_s[i] = elig_s[i]
                && ({1'b0, x_cnt} >= {1'b0, ac_x_r[i]})
                && ({1'b0, x_cnt} <= ({1'b0, ac_x_r[i]} + 11'(CARD_W)))
                && ({1'b0, y_cnt} >= {1'b0, ac_y_r[i]})
                && ({1'b0, y_cnt} <= ({1'b0, ac_y_r[i]} + 11'(CARD_H)));
    end
  end

  // Priority pick: highest covering index is drawn on top
  always_comb begin
    win_idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      win_idx_s = cover_s[i] ? IDX_W'(i) : win_idx_s;
    end
    hit_s = |cover_s;
    if (hit_s) begin
      sel_value_s = ac_val_r[win_idx_s];
      sel_color_s = ac_col_r[win_idx_s];
      sel_x_pin_s = ac_x_r[win_idx_s];
      sel_y_pin_s = ac_y_r[win_idx_s];
    end else begin
      sel_value_s = 4'd0;
      sel_color_s = 2'd0;
      sel_x_pin_s = 10'd0;
      sel_y_pin_s = 10'd0;
    end
  end

  // Registered renderer-side outputs, one clock after x_cnt/y_cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit       <= 1'b0;
      sel_value <= 4'd0;
      sel_color <= 2'd0;
      sel_x_pin <= 10'd0;
      sel_y_pin <= 10'd0;
    end else begin
      hit       <= hit_s;
      sel_value <= sel_value_s;
      sel_color <= sel_color_s;
      sel_x_pin <= sel_x_pin_s;
      sel_y_pin <= sel_y_pin_s;
    end
  end

endmodule

// File: tb/tb_card_slot_scheduler.sv
// Self-checking bench for card_slot_scheduler: directed scenarios plus a
// randomized phase, all checked against a slot-table reference model.
module tb_card_slot_scheduler;

  localparam int NS = 8;
  localparam int CW = 30;
  localparam int CH = 50;

  logic       clk = 1'b0;
  logic       rst_n, frame_start, clear_req, wr_valid, wr_vis, wr_blink;
  logic       wr_ready, hit, busy;
  logic [2:0] wr_slot;
  logic [3:0] wr_value, sel_value;
  logic [1:0] wr_color, sel_color;
  logic [9:0] wr_x, wr_y, x_cnt, y_cnt, sel_x_pin, sel_y_pin;

  card_slot_scheduler #(.NUM_SLOTS(NS), .CARD_W(CW), .CARD_H(CH)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .clear_req(clear_req),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot),
    .wr_value(wr_value), .wr_color(wr_color), .wr_x(wr_x), .wr_y(wr_y),
    .wr_vis(wr_vis), .wr_blink(wr_blink), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .hit(hit), .sel_value(sel_value), .sel_color(sel_color),
    .sel_x_pin(sel_x_pin), .sel_y_pin(sel_y_pin), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vis; int val; int col; int x; int y; bit blink;
  } slot_t;

  slot_t m_sh[NS];
  slot_t m_ac[NS];
  int    m_fc;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_sh[i] = '{1'b0, 0, 0, 0, 0, 1'b0};
      m_ac[i] = '{1'b0, 0, 0, 0, 0, 1'b0};
    end
    m_fc = 0;
  endfunction

  function automatic bit model_elig(input int i);
`ifdef BLINK_EN
    return m_ac[i].vis && !(m_ac[i].blink && ((m_fc / 32) % 2 == 1));
`else
    return m_ac[i].vis;
`endif
  endfunction

  // Topmost eligible slot whose rectangle [pin, pin+size] contains the pixel
  function automatic void model_lookup(input int px, input int py, output bit h,
                                       output int v, output int c, output int xp, output int yp);
    h = 1'b0; v = 0; c = 0; xp = 0; yp = 0;
    for (int i = 0; i < NS; i++) begin
      if (model_elig(i) && px >= m_ac[i].x && px <= m_ac[i].x + CW &&
          py >= m_ac[i].y && py <= m_ac[i].y + CH) begin
        h = 1'b1; v = m_ac[i].val; c = m_ac[i].col; xp = m_ac[i].x; yp = m_ac[i].y;
      end
    end
  endfunction

  // One clock: optionally check wr_ready, then check the registered lookup
  task automatic step(input bit chk_rdy, input bit exp_rdy, input string tag);
    bit h; int v, c, xp, yp;
    #1;
    if (chk_rdy) check_eq({tag, ".rdy"}, 32'(wr_ready), 32'(exp_rdy));
    model_lookup(int'(x_cnt), int'(y_cnt), h, v, c, xp, yp);
    @(posedge clk); #1;
    check_eq({tag, ".hit"}, 32'(hit), 32'(h));
    check_eq({tag, ".val"}, 32'(sel_value), 32'(v));
    check_eq({tag, ".col"}, 32'(sel_color), 32'(c));
    check_eq({tag, ".xp"},  32'(sel_x_pin), 32'(xp));
    check_eq({tag, ".yp"},  32'(sel_y_pin), 32'(yp));
  endtask

  task automatic set_px(input int px, input int py);
    x_cnt = 10'(px);
    y_cnt = 10'(py);
  endtask

  task automatic do_write(input int s, input int v, input int c, input int x, input int y,
                          input bit vis, input bit bl);
    wr_slot = 3'(s); wr_value = 4'(v); wr_color = 2'(c); wr_x = 10'(x); wr_y = 10'(y);
    wr_vis = vis; wr_blink = bl; wr_valid = 1'b1;
    step(1'b1, 1'b1, "wr");
    wr_valid = 1'b0;
    m_sh[s] = '{vis, (v > 9) ? 0 : v, c, x, y, bl};
  endtask

  task automatic do_commit();
    frame_start = 1'b1;
    step(1'b1, 1'b0, "fs");
    frame_start = 1'b0;
    check_eq("commit.busy", 32'(busy), 32'd1);
    step(1'b1, 1'b0, "cm");
    m_ac = m_sh;
    m_fc++;
    check_eq("post_commit.busy", 32'(busy), 32'd0);
  endtask

  // Full clear sweep; optionally a frame_start lands inside the sweep
  task automatic do_clear(input bit with_fs, input int fs_cyc);
    clear_req = 1'b1;
    step(1'b1, 1'b1, "clrq");
    clear_req = 1'b0;
    for (int k = 0; k < NS; k++) begin
      check_eq("clear.busy", 32'(busy), 32'd1);
      frame_start = (with_fs && k == fs_cyc) ? 1'b1 : 1'b0;
      step(1'b1, 1'b0, "clr");
      frame_start = 1'b0;
    end
    for (int i = 0; i < NS; i++) m_sh[i] = '{1'b0, 0, 0, 0, 0, 1'b0};
    if (with_fs) begin
      check_eq("clear_fs.busy", 32'(busy), 32'd1);
      step(1'b1, 1'b0, "clrcm");
      m_ac = m_sh;
      m_fc++;
    end
    check_eq("post_clear.busy", 32'(busy), 32'd0);
  endtask

  function automatic int rnd_pin();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 200));
  endfunction

  initial begin
    int px, py, op, k;
    rst_n = 1'b0; frame_start = 1'b0; clear_req = 1'b0; wr_valid = 1'b0;
    wr_slot = 3'd0; wr_value = 4'd0; wr_color = 2'd0; wr_x = 10'd0; wr_y = 10'd0;
    wr_vis = 1'b0; wr_blink = 1'b0; x_cnt = 10'd0; y_cnt = 10'd0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.hit", 32'(hit), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.val", 32'(sel_value), 32'd0);
    check_eq("rst.xp", 32'(sel_x_pin), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst.rdy", 32'(wr_ready), 32'd1);
    check_eq("rst.busy2", 32'(busy), 32'd0);

    // Write slot 2, invisible until commit, then visible
    do_write(2, 3, 1, 100, 200, 1'b1, 1'b0);
    set_px(115, 225);
    step(1'b1, 1'b1, "precommit");
    check_eq("precommit.hit0", 32'(hit), 32'd0);
    do_commit();
    step(1'b1, 1'b1, "postcommit");
    check_eq("postcommit.hit1", 32'(hit), 32'd1);
    check_eq("postcommit.val3", 32'(sel_value), 32'd3);

    // Rectangle boundaries
    set_px(130, 250); step(1'b1, 1'b1, "edge_in");
    check_eq("edge_in.hit", 32'(hit), 32'd1);
    set_px(131, 250); step(1'b1, 1'b1, "edge_xout");
    check_eq("edge_xout.hit", 32'(hit), 32'd0);
    set_px(130, 251); step(1'b1, 1'b1, "edge_yout");
    set_px(100, 200); step(1'b1, 1'b1, "edge_lo");
    set_px(99, 200);  step(1'b1, 1'b1, "edge_xlo");

    // Overlap priority, then hide the top slot
    do_write(1, 7, 0, 280, 80, 1'b1, 1'b0);
    do_write(5, 9, 3, 290, 90, 1'b1, 1'b0);
    do_commit();
    set_px(300, 100); step(1'b1, 1'b1, "ovl5");
    check_eq("ovl5.val", 32'(sel_value), 32'd9);
    do_write(5, 9, 3, 290, 90, 1'b0, 1'b0);
    do_commit();
    step(1'b1, 1'b1, "ovl1");
    check_eq("ovl1.val", 32'(sel_value), 32'd7);

    // High pin does not alias to zero; reserved value stored as 0
    do_write(7, 5, 2, 1000, 10, 1'b1, 1'b0);
    do_write(3, 12, 1, 500, 500, 1'b1, 1'b0);
    do_write(3, 13, 2, 500, 500, 1'b1, 1'b0);
    do_commit();
    set_px(5, 20);    step(1'b1, 1'b1, "wrap_miss");
    check_eq("wrap_miss.hit", 32'(hit), 32'd0);
    set_px(1023, 20); step(1'b1, 1'b1, "wrap_hit");
    set_px(510, 510); step(1'b1, 1'b1, "resv");
    check_eq("resv.hit", 32'(hit), 32'd1);
    check_eq("resv.val0", 32'(sel_value), 32'd0);
    check_eq("resv.col", 32'(sel_color), 32'd2);

    // clear_req together with frame_start: COMMIT then 8 CLEAR cycles
    do_write(4, 6, 3, 600, 300, 1'b1, 1'b0);
    set_px(610, 310);
    clear_req = 1'b1; frame_start = 1'b1;
    step(1'b1, 1'b0, "clrfs");
    clear_req = 1'b0; frame_start = 1'b0;
    for (int e = 0; e < NS + 1; e++) begin
      check_eq("clrfs.busy", 32'(busy), 32'd1);
      step(1'b1, 1'b0, "clrfs_seq");
      if (e == 0) begin
        m_ac = m_sh;
        m_fc++;
      end
    end
    for (int i = 0; i < NS; i++) m_sh[i] = '{1'b0, 0, 0, 0, 0, 1'b0};
    check_eq("clrfs.done_busy", 32'(busy), 32'd0);
    step(1'b1, 1'b1, "clrfs_idle");
    check_eq("clrfs.slot4", 32'(hit), 32'd1);
    do_commit();
    step(1'b1, 1'b1, "cleared");
    check_eq("cleared.hit", 32'(hit), 32'd0);

    // Frame start landing mid-sweep is committed only after the sweep
    do_write(6, 4, 1, 50, 50, 1'b1, 1'b0);
    do_commit();
    set_px(60, 60);
    do_write(6, 8, 1, 50, 50, 1'b1, 1'b0);
    do_clear(1'b1, 2);
    step(1'b1, 1'b1, "clr_mid_fs");
    check_eq("clr_mid_fs.hit", 32'(hit), 32'd0);

    // Reset asserted in the 3rd CLEAR cycle
    do_write(6, 4, 1, 50, 50, 1'b1, 1'b0);
    do_commit();
    clear_req = 1'b1;
    step(1'b1, 1'b1, "rclr");
    clear_req = 1'b0;
    step(1'b1, 1'b0, "rclr1");
    step(1'b1, 1'b0, "rclr2");
    check_eq("rclr.hit_before", 32'(hit), 32'd1);
    check_eq("rclr.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rclr.hit_async", 32'(hit), 32'd0);
    check_eq("rclr.busy_async", 32'(busy), 32'd0);
    check_eq("rclr.val_async", 32'(sel_value), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rclr.rdy", 32'(wr_ready), 32'd1);
    do_commit();
    step(1'b1, 1'b1, "rclr_empty");
    check_eq("rclr_empty.hit", 32'(hit), 32'd0);

    // Blink slot across 70 frames
    do_write(0, 2, 3, 700, 400, 1'b1, 1'b1);
    set_px(705, 405);
    for (int f = 0; f < 70; f++) begin
      do_commit();
      step(1'b1, 1'b1, "blink");
    end

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, NS - 1);
      px = ($urandom_range(0, 1) == 0) ? m_ac[k].x : m_sh[k].x;
      py = ($urandom_range(0, 1) == 0) ? m_ac[k].y : m_sh[k].y;
      px = px + int'($urandom_range(0, CW + 4)) - 2;
      py = py + int'($urandom_range(0, CH + 4)) - 2;
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      if (py < 0) py = 0;
      if (py > 1023) py = 1023;
      set_px(px, py);
      op = $urandom_range(0, 19);
      if (op < 10) begin
        do_write(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), rnd_pin(), rnd_pin(),
                 ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
      end else if (op < 15) begin
        do_commit();
      end else if (op == 15) begin
        do_clear(1'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)));
      end else begin
        step(1'b1, 1'b1, "rnd_idle");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
